traffic_phase_controller: RTL

TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

---
 rtl/traffic_phase_controller_pkg.sv | 20 ++
 rtl/traffic_phase_controller_timer.sv | 23 ++
 rtl/traffic_phase_controller.sv | 74 +++++++
 3 files changed

// File: rtl/traffic_phase_controller_pkg.sv
// traffic_phase_controller_pkg: shared phase encoding, light constants and time clamp
package traffic_phase_controller_pkg;
  localparam logic [6:0] MAX_TIME = 7'd99;
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_AMBER  = 3'd1,
    RED_TO_SEC  = 3'd2,
    SEC_GREEN   = 3'd3,
    SEC_AMBER   = 3'd4,
    RED_TO_MAIN = 3'd5,
    FLASH       = 3'd6
  } phase_t;
  localparam logic [2:0] LIGHT_RED   = 3'b100;
  localparam logic [2:0] LIGHT_AMBER = 3'b010;
  localparam logic [2:0] LIGHT_GREEN = 3'b001;
  localparam logic [2:0] LIGHT_OFF   = 3'b000;
  function automatic logic [6:0] clamp_time(input logic [6:0] t);
    return t == 7'd0 ? 7'd1 : (t > MAX_TIME ? MAX_TIME : t);
  endfunction
endpackage

// File: rtl/traffic_phase_controller_timer.sv
// traffic_phase_controller_timer: per-phase seconds counter with clamped load and tick decrement
module traffic_phase_controller_timer
  import traffic_phase_controller_pkg::*;
#(
  parameter logic [6:0] RESET_VAL = 7'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic       clear,
  input  logic [6:0] din,
  output logic [6:0] count,
  output logic       done
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= RESET_VAL;
    else if (clear) count <= '0;
    else if (load) count <= clamp_time(din);
    else if (tick && count > 7'd1) count <= count - 7'd1;
  end
  assign done = count == 7'd1;
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: two-road signal sequencer with main-road hold and night flash mode
module traffic_phase_controller
  import traffic_phase_controller_pkg::*;
#(
  parameter int TRED = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [6:0] Ta,
  input  logic [6:0] Tpv,
  input  logic [6:0] Tsv,
  input  logic       sec_req,
  input  logic       flash_en,
  output logic [2:0] mainLight,
  output logic [2:0] secLight,
  output logic [6:0] timeRemaining,
  output logic [2:0] phase
);
  localparam logic [6:0] TRED_T = 7'(TRED);
  phase_t state, state_n;
  logic toggle, toggle_n, load, clear, done;
  logic [6:0] load_val;
  logic [2:0] main_n, sec_n;
  traffic_phase_controller_timer #(.RESET_VAL(clamp_time(TRED_T))) u_timer (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .clear(clear),
    .din(load_val), .count(timeRemaining), .done(done)
  );
  always_comb begin
    state_n = state;
    toggle_n = toggle;
    load = 1'b0;
    clear = 1'b0;
    if (tick) begin
      case (state)
        MAIN_GREEN:  state_n = flash_en ? FLASH : (done && sec_req) ? MAIN_AMBER : MAIN_GREEN;
        MAIN_AMBER:  state_n = done ? RED_TO_SEC : MAIN_AMBER;
        RED_TO_SEC:  state_n = done ? SEC_GREEN : RED_TO_SEC;
        SEC_GREEN:   state_n = done ? SEC_AMBER : SEC_GREEN;
        SEC_AMBER:   state_n = done ? RED_TO_MAIN : SEC_AMBER;
        RED_TO_MAIN: state_n = flash_en ? FLASH : done ? MAIN_GREEN : RED_TO_MAIN;
        FLASH:       state_n = flash_en ? FLASH : RED_TO_MAIN;
        default:     state_n = RED_TO_MAIN;
      endcase
      // toggle starts from 0 outside FLASH, so the entry tick lights amber first
      toggle_n = state_n == FLASH ? ~toggle : 1'b0;
      clear = state_n == FLASH && state != FLASH;
      load = state_n != state && state_n != FLASH;
    end
    load_val = state_n == MAIN_GREEN ? Tpv :
               state_n == SEC_GREEN ? Tsv :
               (state_n == MAIN_AMBER || state_n == SEC_AMBER) ? Ta : TRED_T;
    main_n = state_n == FLASH ? (toggle_n ? LIGHT_AMBER : LIGHT_OFF) :
             state_n == MAIN_GREEN ? LIGHT_GREEN :
             state_n == MAIN_AMBER ? LIGHT_AMBER : LIGHT_RED;
    sec_n = state_n == FLASH ? (toggle_n ? LIGHT_AMBER : LIGHT_OFF) :
            state_n == SEC_GREEN ? LIGHT_GREEN :
            state_n == SEC_AMBER ? LIGHT_AMBER : LIGHT_RED;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RED_TO_MAIN;
      toggle <= 1'b0;
      mainLight <= LIGHT_RED;
      secLight <= LIGHT_RED;
    end else begin
      state <= state_n;
      toggle <= toggle_n;
      mainLight <= main_n;
      secLight <= sec_n;
    end
  end
  assign phase = state;
endmodule
